// File: rtl/ofdm_pkg.sv
// Shared OFDM constants and the cyclic-prefix FSM state encoding.
// Used by the TX prefix inserter and the RX prefix-removal stage.
package ofdm_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned SYMBOL_LEN_DEF = 32;
  localparam int unsigned CP_LEN_DEF     = 4;

  typedef enum logic [1:0] {
    StFill,
    StEmitCp,
    StEmitSym
  } cp_state_e;

endpackage

// File: rtl/ofdm_symbol_ram.sv
// One-symbol sample buffer: DEPTH x DATA_W words.
// Ports:
//   clk    clock, write on rising edge
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  asynchronous read data for raddr
module ofdm_symbol_ram
  import ofdm_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = SYMBOL_LEN_DEF,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ofdm_prefix_insert.sv
// TX cyclic-prefix inserter. Buffers one OFDM symbol from the Avalon-ST sink and
// emits it as one packet: the last CP_LEN words, then all SYMBOL_LEN words.
// Ports:
//   clock_clk, reset_reset          clock, asynchronous active-high reset
//   asi_in0_*                       Avalon-ST sink (data/valid/ready/sop/eop)
//   aso_out0_*                      Avalon-ST source (data/valid/ready/sop/eop)
//   drop_pulse                      one-cycle pulse when a malformed symbol is discarded
module ofdm_prefix_insert
  import ofdm_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned SYMBOL_LEN = SYMBOL_LEN_DEF,
  parameter int unsigned CP_LEN     = CP_LEN_DEF
) (
  input  logic              clock_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] asi_in0_data,
  input  logic              asi_in0_valid,
  output logic              asi_in0_ready,
  input  logic              asi_in0_startofpacket,
  input  logic              asi_in0_endofpacket,
  output logic [DATA_W-1:0] aso_out0_data,
  output logic              aso_out0_valid,
  input  logic              aso_out0_ready,
  output logic              aso_out0_startofpacket,
  output logic              aso_out0_endofpacket,
  output logic              drop_pulse
);

  localparam int unsigned IW = $clog2(SYMBOL_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(SYMBOL_LEN - 1);
  localparam logic [IW-1:0] CP_START = IW'(SYMBOL_LEN - CP_LEN);

  cp_state_e         state_q, state_d;
  logic [IW-1:0]     wr_idx_q, wr_idx_d;
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic              have_sop_q, have_sop_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic              drop_q, drop_d;

  logic              ram_we;
  logic [IW-1:0]     ram_waddr;
  logic [IW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              out_accept;
  logic [IW-1:0]     rd_next;

  ofdm_symbol_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (SYMBOL_LEN),
    .AW     (IW)
  ) u_ram (
    .clk   (clock_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (asi_in0_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign out_accept = out_valid_q && aso_out0_ready;
  // Index of the word after the one on the output; leaving EMIT_CP restarts at 0.
  assign rd_next    = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IW'(1);

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    have_sop_d  = have_sop_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    drop_d      = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = wr_idx_q;
    ram_raddr   = CP_START;

    unique case (state_q)
      StFill: begin
        if (asi_in0_valid) begin
          if (asi_in0_startofpacket && asi_in0_endofpacket) begin
            // A one-word symbol is never legal, so this is an early EOP.
            drop_d     = 1'b1;
            wr_idx_d   = '0;
            have_sop_d = 1'b0;
          end else if (asi_in0_startofpacket) begin
            ram_we     = 1'b1;
            ram_waddr  = '0;
            wr_idx_d   = IW'(1);
            have_sop_d = 1'b1;
            drop_d     = have_sop_q;
          end else if (have_sop_q) begin
            ram_we = 1'b1;
            if (wr_idx_q == LAST_IDX) begin
              // Preload the first CP word now so valid rises on the next cycle.
              // With CP_LEN=1 that word is the one being written this cycle.
              state_d     = StEmitCp;
              rd_idx_d    = CP_START;
              wr_idx_d    = '0;
              have_sop_d  = 1'b0;
              out_valid_d = 1'b1;
              out_sop_d   = 1'b1;
              out_eop_d   = 1'b0;
              out_data_d  = (CP_START == LAST_IDX) ? asi_in0_data : ram_rdata;
            end else if (asi_in0_endofpacket) begin
              ram_we     = 1'b0;
              drop_d     = 1'b1;
              wr_idx_d   = '0;
              have_sop_d = 1'b0;
            end else begin
              wr_idx_d = wr_idx_q + IW'(1);
            end
          end
        end
      end

      StEmitCp: begin
        ram_raddr = rd_next;
        if (out_accept) begin
          out_data_d = ram_rdata;
          out_sop_d  = 1'b0;
          out_eop_d  = 1'b0;
          rd_idx_d   = rd_next;
          if (rd_idx_q == LAST_IDX) begin
            state_d = StEmitSym;
          end
        end
      end

      StEmitSym: begin
        ram_raddr = rd_next;
        if (out_accept) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d     = StFill;
            rd_idx_d    = '0;
            wr_idx_d    = '0;
            have_sop_d  = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
          end else begin
            rd_idx_d   = rd_next;
            out_data_d = ram_rdata;
            out_eop_d  = (rd_next == LAST_IDX);
          end
        end
      end

      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= StFill;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      have_sop_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      have_sop_q  <= have_sop_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      drop_q      <= drop_d;
    end
  end

  assign asi_in0_ready          = (state_q == StFill);
  assign aso_out0_data          = out_data_q;
  assign aso_out0_valid         = out_valid_q;
  assign aso_out0_startofpacket = out_sop_q;
  assign aso_out0_endofpacket   = out_eop_q;
  assign drop_pulse             = drop_q;

endmodule

// File: tb/tb_ofdm_prefix_insert.sv
// Self-checking bench for ofdm_prefix_insert (SYMBOL_LEN=32, CP_LEN=4).
module tb_ofdm_prefix_insert;

  localparam int unsigned DW = 32;
  localparam int unsigned SL = 32;
  localparam int unsigned CL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sop;
  logic          out_eop;
  logic          drop;

  always #5 clk = ~clk;

  ofdm_prefix_insert #(
    .DATA_W     (DW),
    .SYMBOL_LEN (SL),
    .CP_LEN     (CL)
  ) dut (
    .clock_clk              (clk),
    .reset_reset            (rst),
    .asi_in0_data           (in_data),
    .asi_in0_valid          (in_valid),
    .asi_in0_ready          (in_ready),
    .asi_in0_startofpacket  (in_sop),
    .asi_in0_endofpacket    (in_eop),
    .aso_out0_data          (out_data),
    .aso_out0_valid         (out_valid),
    .aso_out0_ready         (out_ready),
    .aso_out0_startofpacket (out_sop),
    .aso_out0_endofpacket   (out_eop),
    .drop_pulse             (drop)
  );

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    drop_cnt = 0;
  int    exp_drops = 0;
  int    rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: symbol assembly by plain list rules.
  logic [DW-1:0] m_sym[$];
  bit            m_have = 0;

  task automatic model_beat(input logic [DW-1:0] d, input bit s, input bit e);
    if (s && e) begin
      exp_drops++;
      m_have = 0;
      m_sym.delete();
    end else if (s) begin
      if (m_have) exp_drops++;
      m_sym.delete();
      m_sym.push_back(d);
      m_have = 1;
    end else if (m_have) begin
      m_sym.push_back(d);
      if (m_sym.size() == SL) begin
        for (int i = SL - CL; i < SL; i++)
          exp_q.push_back('{sop: (i == SL - CL), eop: 1'b0, data: m_sym[i]});
        for (int i = 0; i < SL; i++)
          exp_q.push_back('{sop: 1'b0, eop: (i == SL - 1), data: m_sym[i]});
        m_have = 0;
        m_sym.delete();
      end else if (e) begin
        exp_drops++;
        m_have = 0;
        m_sym.delete();
      end
    end
  endtask

  // Output monitor: collects accepted beats, counts drop pulses, checks stall hold.
  bit    prev_stall = 0;
  beat_t prev_beat;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (drop) drop_cnt++;
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'({out_sop, out_eop, out_data}), 64'(prev_beat));
      end
      if (out_valid) begin
        check("in_ready_low", 64'(in_ready), 64'd0);
        if (out_ready) got_q.push_back('{sop: out_sop, eop: out_eop, data: out_data});
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = '{sop: out_sop, eop: out_eop, data: out_data};
    end
  end

  // Source-ready pattern generator.
  initial begin
    int hold = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: begin
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
          end else if ($urandom_range(0, 3) == 0) begin
            out_ready = 1'b0;
            hold = int'($urandom_range(0, 4));
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit s, input bit e);
    int  t = 0;
    bit  done = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_sop   = s;
    in_eop   = e;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else if (++t > 500) begin
        check("sink_timeout", 64'd0, 64'd1);
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    model_beat(d, s, e);
  endtask

  task automatic send_run(input logic [DW-1:0] base, input int n, input bit s, input bit e);
    for (int i = 0; i < n; i++) send(base + DW'(i), s && (i == 0), e && (i == n - 1));
  endtask

  task automatic finish_scn(input string name, input int want_drops);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    check({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
    check({name, "_drops"}, 64'(drop_cnt), 64'(want_drops));
    got_q.delete();
    exp_q.delete();
    drop_cnt  = 0;
    exp_drops = 0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string         name;
    int            base;
    int            junk;
    int            trunc;
    int            restart;
    int            drops;
    logic [DW-1:0] first;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"nominal",     0,   0, 0,  0, 0, 32'd28};
    vecs[1] = '{"early_eop",   100, 0, 10, 0, 1, 32'd128};
    vecs[2] = '{"sop_restart", 200, 0, 0,  5, 1, 32'd228};
    vecs[3] = '{"junk",        300, 7, 0,  0, 0, 32'd328};
    vecs[4] = '{"sop_eop_one", 400, 0, 1,  0, 1, 32'd428};

    // Reset state.
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_flags", 64'({out_sop, out_eop, drop}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven single-symbol scenarios at full source throughput.
    rdy_mode = 0;
    foreach (vecs[v]) begin
      for (int j = 0; j < vecs[v].junk; j++) send(32'hdead_0000 + DW'(j), 1'b0, (j == 2));
      if (vecs[v].trunc > 0) send_run(32'h5000, vecs[v].trunc, 1'b1, 1'b1);
      if (vecs[v].restart > 0) send_run(32'h6000, vecs[v].restart, 1'b1, 1'b0);
      send_run(DW'(vecs[v].base), SL, 1'b1, 1'b1);
      // Completing beat was accepted on the previous edge: first CP word is already up.
      check({vecs[v].name, "_latency"}, 64'(out_valid), 64'd1);
      check({vecs[v].name, "_first"}, 64'(out_data), 64'(vecs[v].first));
      check({vecs[v].name, "_first_sop"}, 64'(out_sop), 64'd1);
      finish_scn(vecs[v].name, vecs[v].drops);
    end

    // Backpressure: strict toggle, then random low holds up to 5 cycles.
    rdy_mode = 1;
    send_run(32'd600, SL, 1'b1, 1'b1);
    finish_scn("bp_toggle", 0);
    rdy_mode = 2;
    send_run(32'd700, SL, 1'b1, 1'b1);
    finish_scn("bp_random", 0);

    // Asynchronous reset in the middle of emission.
    rdy_mode = 0;
    send_run(32'd800, SL, 1'b1, 1'b1);
    begin
      int t = 0;
      while (got_q.size() < 11 && t < 500) begin
        @(negedge clk);
        t++;
      end
      check("mid_rst_reached", 64'(got_q.size() >= 11), 64'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_flags", 64'({out_sop, out_eop, drop}), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    got_q.delete();
    exp_q.delete();
    m_sym.delete();
    m_have    = 0;
    drop_cnt  = 0;
    exp_drops = 0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_silent", 64'(got_q.size()), 64'd0);
    @(posedge clk);
    #1;
    send_run(32'd900, SL, 1'b1, 1'b1);
    finish_scn("post_rst", 0);

    // Randomised episodes against the reference model.
    rdy_mode = 2;
    for (int ep = 0; ep < 40; ep++) begin
      int kind = int'($urandom_range(0, 9));
      case (kind)
        0: for (int j = 0; j < int'($urandom_range(1, 5)); j++)
             send($urandom, 1'b0, 1'($urandom_range(0, 1)));
        1: send_run($urandom, int'($urandom_range(1, SL - 1)), 1'b1, 1'b1);
        2: send_run($urandom, int'($urandom_range(1, SL - 1)), 1'b1, 1'b0);
        3: send_run($urandom, SL, 1'b1, 1'b0);
        default: send_run($urandom, SL, 1'b1, 1'b1);
      endcase
    end
    send_run($urandom, SL, 1'b1, 1'b1);
    finish_scn("random", exp_drops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
